// File: rtl/display_arbiter_if.sv
// display_arbiter_if: requester/display-side signals of the display arbiter
interface display_arbiter_if;
  logic [3:0] req_i;
  logic [63:0] data_i;
  logic [3:0] ack_o;
  logic [1:0] owner_o;
  logic busy_o;
  logic [15:0] reg_16_o;
  modport master (output req_i, data_i, input ack_o, owner_o, busy_o, reg_16_o);
  modport slave (input req_i, data_i, output ack_o, owner_o, busy_o, reg_16_o);
endinterface

// File: rtl/display_arbiter.sv
// display_arbiter: round-robin sharing of the 7-segment display with a minimum hold time per owner
module display_arbiter #(
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter logic [15:0] IDLE_VALUE = 16'h0000
) (
  input logic clk_i,
  input logic rst_i,
  display_arbiter_if.slave bus
);
  localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0] ptr, ptr_n, owner, owner_n, win;
  logic [3:0] ack, ack_n;
  logic [15:0] val, val_n;
  logic expire, grant, refresh;
  // search starts just after the pointer; the pointer itself (last winner) comes last
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    pick = p;
    for (int i = 4; i >= 1; i--)
      if (r[p + 2'(i)]) pick = p + 2'(i);
  endfunction
  always_comb begin
    win = pick(bus.req_i, ptr);
    expire = state == HOLD && cnt == CW'(HOLD_CYCLES - 1);
    grant = |bus.req_i && (state == IDLE || expire);
    refresh = state == HOLD && !expire && bus.req_i[owner];
    state_n = grant ? HOLD : expire ? IDLE : state;
    cnt_n = (grant || expire || state == IDLE) ? '0 : cnt + CW'(1);
    ptr_n = grant ? win : ptr;
    owner_n = grant ? win : owner;
    ack_n = grant ? 4'(1) << win : refresh ? 4'(1) << owner : 4'b0;
    val_n = grant ? bus.data_i[16*win +: 16] : refresh ? bus.data_i[16*owner +: 16] : val;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
      ptr <= 2'd3;
      owner <= 2'd0;
      ack <= 4'b0;
      val <= IDLE_VALUE;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      ptr <= ptr_n;
      owner <= owner_n;
      ack <= ack_n;
      val <= val_n;
    end
  end
  assign bus.ack_o = ack;
  assign bus.owner_o = owner;
  assign bus.busy_o = state == HOLD;
  assign bus.reg_16_o = val;
endmodule

// File: tb/tb_display_arbiter.sv
// tb_display_arbiter: directed checks of the display arbiter at HOLD_CYCLES=4 and HOLD_CYCLES=1
module tb_display_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst1 = 1'b1;
  int checks = 0;
  int failures = 0;
  display_arbiter_if bus4();
  display_arbiter_if bus1();
  display_arbiter #(.HOLD_CYCLES(4), .IDLE_VALUE(16'h0000)) dut4 (.clk_i(clk), .rst_i(rst), .bus(bus4));
  display_arbiter #(.HOLD_CYCLES(1), .IDLE_VALUE(16'h0000)) dut1 (.clk_i(clk), .rst_i(rst1), .bus(bus1));
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    bus4.req_i = 4'h0;
    step();
    rst = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    bus4.req_i = 4'hF;
    bus4.data_i = 64'h4444_3333_2222_1111;
    step();
    step();
    checks++;
    if (bus4.reg_16_o !== 16'h0000) begin failures++; $display("FAIL reset_reg got=%h exp=0000", bus4.reg_16_o); end
    checks++;
    if (bus4.ack_o !== 4'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0000", bus4.ack_o); end
    checks++;
    if (bus4.busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus4.busy_o); end
    checks++;
    if (bus4.owner_o !== 2'd0) begin failures++; $display("FAIL reset_owner got=%0d exp=0", bus4.owner_o); end
    rst = 1'b0;
    bus4.req_i = 4'h0;
  endtask
  task automatic test_single;
    bus4.req_i = 4'b0010;
    bus4.data_i = 64'h0000_0000_BEEF_0000;
    step();
    checks++;
    if (bus4.ack_o !== 4'b0010) begin failures++; $display("FAIL single_ack got=%b exp=0010", bus4.ack_o); end
    checks++;
    if (bus4.reg_16_o !== 16'hBEEF) begin failures++; $display("FAIL single_reg got=%h exp=beef", bus4.reg_16_o); end
    checks++;
    if (bus4.owner_o !== 2'd1) begin failures++; $display("FAIL single_owner got=%0d exp=1", bus4.owner_o); end
    bus4.req_i = 4'h0;
    bus4.data_i = 64'h0;
    for (int c = 2; c <= 4; c++) begin
      step();
      checks++;
      if (bus4.busy_o !== 1'b1 || bus4.ack_o !== 4'b0) begin
        failures++;
        $display("FAIL single_hold cycle=%0d busy=%b ack=%b exp busy=1 ack=0000", c, bus4.busy_o, bus4.ack_o);
      end
    end
    step();
    checks++;
    if (bus4.busy_o !== 1'b0) begin failures++; $display("FAIL single_release busy got=%b exp=0", bus4.busy_o); end
    checks++;
    if (bus4.reg_16_o !== 16'hBEEF) begin failures++; $display("FAIL single_keep reg got=%h exp=beef", bus4.reg_16_o); end
  endtask
  task automatic test_round_robin;
    int up [4];
    logic [1:0] exp_owner;
    do_reset();
    for (int n = 0; n < 4; n++) up[n] = -1;
    bus4.data_i = 64'hDDDD_CCCC_BBBB_AAAA;
    bus4.req_i = 4'hF;
    for (int c = 1; c <= 17; c++) begin
      step();
      checks++;
      if (!$onehot0(bus4.ack_o)) begin failures++; $display("FAIL rr_onehot cycle=%0d ack=%b", c, bus4.ack_o); end
      if ((c - 1) % 4 == 0) begin
        exp_owner = 2'((c - 1) / 4);
        checks++;
        if (bus4.owner_o !== exp_owner || bus4.ack_o !== 4'(1) << exp_owner) begin
          failures++;
          $display("FAIL rr_grant cycle=%0d owner=%0d ack=%b exp owner=%0d", c, bus4.owner_o, bus4.ack_o, exp_owner);
        end
      end
      for (int n = 0; n < 4; n++) begin
        if (bus4.ack_o[n]) begin
          bus4.req_i[n] = 1'b0;
          up[n] = c + 2;
        end else if (up[n] == c) bus4.req_i[n] = 1'b1;
      end
    end
    bus4.req_i = 4'h0;
  endtask
  task automatic test_refresh;
    do_reset();
    bus4.req_i = 4'b0100;
    bus4.data_i = 64'h0000_1234_0000_0000;
    step();
    checks++;
    if (bus4.reg_16_o !== 16'h1234 || bus4.ack_o !== 4'b0100) begin
      failures++;
      $display("FAIL refresh_grant reg=%h ack=%b exp reg=1234 ack=0100", bus4.reg_16_o, bus4.ack_o);
    end
    bus4.req_i = 4'h0;
    step();
    checks++;
    if (bus4.ack_o !== 4'b0) begin failures++; $display("FAIL refresh_gap ack got=%b exp=0000", bus4.ack_o); end
    bus4.req_i = 4'b0100;
    bus4.data_i = 64'h0000_5678_0000_0000;
    step();
    checks++;
    if (bus4.reg_16_o !== 16'h5678 || bus4.ack_o !== 4'b0100) begin
      failures++;
      $display("FAIL refresh_update reg=%h ack=%b exp reg=5678 ack=0100", bus4.reg_16_o, bus4.ack_o);
    end
    bus4.req_i = 4'h0;
    bus4.data_i = 64'h0000_9999_0000_0000;
    step();
    checks++;
    if (bus4.busy_o !== 1'b1) begin failures++; $display("FAIL refresh_busy4 got=%b exp=1", bus4.busy_o); end
    step();
    checks++;
    if (bus4.busy_o !== 1'b0 || bus4.reg_16_o !== 16'h5678) begin
      failures++;
      $display("FAIL refresh_expiry busy=%b reg=%h exp busy=0 reg=5678", bus4.busy_o, bus4.reg_16_o);
    end
  endtask
  task automatic test_reset_mid_hold;
    do_reset();
    bus4.req_i = 4'b0010;
    bus4.data_i = 64'h3333_0000_AAAA_1111;
    step();
    bus4.req_i = 4'h0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (bus4.reg_16_o !== 16'h0000 || bus4.ack_o !== 4'b0 || bus4.busy_o !== 1'b0 || bus4.owner_o !== 2'd0) begin
      failures++;
      $display("FAIL midhold_reset reg=%h ack=%b busy=%b owner=%0d exp all zero", bus4.reg_16_o, bus4.ack_o, bus4.busy_o, bus4.owner_o);
    end
    bus4.req_i = 4'b1001;
    step();
    checks++;
    if (bus4.owner_o !== 2'd0 || bus4.ack_o !== 4'b0001 || bus4.reg_16_o !== 16'h1111) begin
      failures++;
      $display("FAIL midhold_ptr owner=%0d ack=%b reg=%h exp owner=0 ack=0001 reg=1111", bus4.owner_o, bus4.ack_o, bus4.reg_16_o);
    end
    bus4.req_i = 4'h0;
  endtask
  task automatic test_hold1;
    logic [1:0] exp_owner;
    rst1 = 1'b1;
    bus1.req_i = 4'b0011;
    bus1.data_i = 64'h0000_0000_000B_000A;
    step();
    step();
    checks++;
    if (bus1.busy_o !== 1'b0 || bus1.owner_o !== 2'd0) begin
      failures++;
      $display("FAIL hold1_reset busy=%b owner=%0d exp busy=0 owner=0", bus1.busy_o, bus1.owner_o);
    end
    rst1 = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      step();
      exp_owner = 2'((c - 1) % 2);
      checks++;
      if (bus1.owner_o !== exp_owner || bus1.ack_o !== 4'(1) << exp_owner || bus1.busy_o !== 1'b1
          || bus1.reg_16_o !== (exp_owner == 2'd0 ? 16'h000A : 16'h000B)) begin
        failures++;
        $display("FAIL hold1_rotate cycle=%0d owner=%0d ack=%b busy=%b reg=%h exp owner=%0d", c, bus1.owner_o, bus1.ack_o, bus1.busy_o, bus1.reg_16_o, exp_owner);
      end
    end
    bus1.req_i = 4'h0;
  endtask
  initial begin
    bus4.req_i = 4'h0;
    bus4.data_i = 64'h0;
    bus1.req_i = 4'h0;
    bus1.data_i = 64'h0;
    test_reset();
    test_single();
    test_round_robin();
    test_refresh();
    test_reset_mid_hold();
    test_hold1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
